// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller running entirely on iclk; tck/tms/tdi are oversampled as async data.
// Latency: tck pin rise to state change is SYNC_STAGES+1 iclk edges; strobes are 1-cycle pulses.
// Backpressure: none; tck phases must each last at least SYNC_STAGES+2 iclk cycles.
//
// Ports: iclk/resetn       clock, async active-low reset
//        tck/tms/tdi        raw JTAG pins (asynchronous to iclk)
//        tdo/tdo_en         serial out and driver enable, updated on tck falls
//        tdi_s              synchronised tdi for the IR/DR serial inputs
//        ir_so/dr_so        serial outputs of the IR and the selected DR
//        shift_*/clk_*/update_*  IR and DR control levels and strobes
//        tlr/tap_state      Test-Logic-Reset level and current state code
module dp_tap_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       iclk,
    input  logic       resetn,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    output logic       tdi_s,
    input  logic       ir_so,
    input  logic       dr_so,
    output logic       shift_ir,
    output logic       clk_ir,
    output logic       update_ir,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic       tlr,
    output logic [3:0] tap_state
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e state_q;
    tap_state_e state_d;

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic                   tck_d;
    logic [SYNC_STAGES:0]   prime;
    logic                   sync_tck;
    logic                   sync_tms;
    logic                   armed;
    logic                   tck_rise;
    logic                   tck_fall;

    // All three pins go through identical chains so tms/tdi stay aligned with tck.
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_d    <= 1'b0;
            prime    <= '0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_d    <= sync_tck;
            prime    <= {prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_tck = tck_sync[SYNC_STAGES-1];
    assign sync_tms = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];

    // The chains restart from 0 after reset, so a tck already high at release
    // would look like a rise. Edges are masked until the chain and tck_d both
    // hold real pin samples (SYNC_STAGES+1 cycles after release).
    assign armed    = prime[SYNC_STAGES];
    assign tck_rise = armed & sync_tck & ~tck_d;
    assign tck_fall = armed & ~sync_tck & tck_d;

    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = sync_tms ? TLR    : RTI;
                RTI:     state_d = sync_tms ? SEL_DR : RTI;
                SEL_DR:  state_d = sync_tms ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = sync_tms ? EX1_DR : SH_DR;
                SH_DR:   state_d = sync_tms ? EX1_DR : SH_DR;
                EX1_DR:  state_d = sync_tms ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = sync_tms ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = sync_tms ? UPD_DR : SH_DR;
                UPD_DR:  state_d = sync_tms ? SEL_DR : RTI;
                SEL_IR:  state_d = sync_tms ? TLR    : CAP_IR;
                CAP_IR:  state_d = sync_tms ? EX1_IR : SH_IR;
                SH_IR:   state_d = sync_tms ? EX1_IR : SH_IR;
                EX1_IR:  state_d = sync_tms ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = sync_tms ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = sync_tms ? UPD_IR : SH_IR;
                UPD_IR:  state_d = sync_tms ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // Strobes look at the state held during the edge cycle, so a capture/shift
    // pulse is qualified by the state it belongs to, not the one it leads to.
    assign shift_ir  = (state_q == SH_IR);
    assign shift_dr  = (state_q == SH_DR);
    assign tlr       = (state_q == TLR);
    assign tap_state = state_q;
    assign clk_ir    = tck_rise & ((state_q == CAP_IR) | (state_q == SH_IR));
    assign clk_dr    = tck_rise & ((state_q == CAP_DR) | (state_q == SH_DR));
    assign update_ir = tck_fall & (state_q == UPD_IR);
    assign update_dr = tck_fall & (state_q == UPD_DR);

    // tdo changes on falling tck so the external debugger samples a stable bit
    // on the next rise; outside the shift states the last bit is held.
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (tck_fall) begin
            if (state_q == SH_IR) begin
                tdo    <= ir_so;
                tdo_en <= 1'b1;
            end else if (state_q == SH_DR) begin
                tdo    <= dr_so;
                tdo_en <= 1'b1;
            end else begin
                tdo_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Directed bench for dp_tap_ctrl: pins driven on falling iclk, outputs sampled on falling iclk.
// Latency: each tck half-phase lasts HALF iclk cycles, well above the synchroniser requirement.
// Backpressure: none; all waits are fixed cycle counts.
module tb_dp_tap_ctrl;

    localparam int SS   = 2;
    localparam int HALF = 6;

    logic       iclk = 1'b0;
    logic       resetn = 1'b0;
    logic       tck = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       ir_so = 1'b0;
    logic       dr_so = 1'b0;
    logic       tdo, tdo_en, tdi_s;
    logic       shift_ir, clk_ir, update_ir;
    logic       shift_dr, clk_dr, update_dr;
    logic       tlr;
    logic [3:0] tap_state;

    dp_tap_ctrl #(.SYNC_STAGES(SS)) dut (
        .iclk      (iclk),
        .resetn    (resetn),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .tdi_s     (tdi_s),
        .ir_so     (ir_so),
        .dr_so     (dr_so),
        .shift_ir  (shift_ir),
        .clk_ir    (clk_ir),
        .update_ir (update_ir),
        .shift_dr  (shift_dr),
        .clk_dr    (clk_dr),
        .update_dr (update_dr),
        .tlr       (tlr),
        .tap_state (tap_state)
    );

    always #5 iclk = ~iclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitors
    int         c_clk_ir = 0, c_sh_ir = 0, c_upd_ir = 0;
    int         c_clk_dr = 0, c_sh_dr = 0, c_upd_dr = 0, c_pau_dr = 0;
    int         c_any = 0;
    logic [7:0] ir_cap = 8'h00;
    logic [3:0] upd_ir_st = 4'h0;

    always @(negedge iclk) begin
        if (clk_ir) c_clk_ir++;
        if (clk_ir && shift_ir) begin
            c_sh_ir++;
            ir_cap = {tdi_s, ir_cap[7:1]};
        end
        if (update_ir) begin
            c_upd_ir++;
            upd_ir_st = tap_state;
        end
        if (clk_dr) c_clk_dr++;
        if (clk_dr && shift_dr) c_sh_dr++;
        if (clk_dr && tap_state == 4'h3) c_pau_dr++;
        if (update_dr) c_upd_dr++;
        if (clk_ir || clk_dr || update_ir || update_dr) c_any++;
    end

    task automatic clear_counts();
        c_clk_ir = 0; c_sh_ir = 0; c_upd_ir = 0;
        c_clk_dr = 0; c_sh_dr = 0; c_upd_dr = 0; c_pau_dr = 0;
        c_any = 0;
        ir_cap = 8'h00;
    endtask

    // One full tck period: setup low, high, low.
    task automatic tck_cycle(input logic m, input logic d);
        tms = m;
        tdi = d;
        repeat (HALF) @(negedge iclk);
        tck = 1'b1;
        repeat (HALF) @(negedge iclk);
        tck = 1'b0;
        repeat (HALF) @(negedge iclk);
    endtask

    // Paths from TLR to every state: bit j is tms for the j-th tck.
    logic [7:0] path_bits [16] = '{8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd10, 8'd10, 8'd42,
                                   8'd26, 8'd6, 8'd6, 8'd6, 8'd22, 8'd22, 8'd86, 8'd54};
    int         path_len  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [3:0] path_st   [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                                   4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

    logic [7:0]  pat;
    logic [9:0]  tms_v10;
    logic [9:0]  ir_v10;
    logic [15:0] tms_v16;
    logic [15:0] dr_v16;

    initial begin
        // ---------------- reset with tck toggling ----------------
        for (int i = 0; i < 6; i++) begin
            repeat (3) @(negedge iclk);
            tck = ~tck;
        end
        repeat (3) @(negedge iclk);
        chk("rst_state", tap_state, 4'hF);
        chk("rst_tlr", tlr, 1'b1);
        chk("rst_tdo_en", tdo_en, 1'b0);
        chk("rst_tdo", tdo, 1'b0);
        chk("rst_strobes", c_any, 0);
        tck = 1'b0;
        tms = 1'b0;
        @(negedge iclk);
        resetn = 1'b1;
        repeat (HALF) @(negedge iclk);
        tck_cycle(1'b0, 1'b0);
        chk("rst_to_rti", tap_state, 4'hC);

        // ---------------- 8-bit IR scan of 0xA5 ----------------
        clear_counts();
        pat = 8'hA5;
        for (int i = 0; i < 14; i++) begin
            tck_cycle((i < 2) || (i == 11) || (i == 12),
                      (i >= 4 && i <= 11) ? pat[i-4] : 1'b0);
        end
        chk("ir_clk_cnt", c_clk_ir, 9);
        chk("ir_shift_cnt", c_sh_ir, 8);
        chk("ir_upd_cnt", c_upd_ir, 1);
        chk("ir_upd_state", upd_ir_st, 4'hD);
        chk("ir_tdi_data", ir_cap, 8'hA5);
        chk("ir_no_dr", c_clk_dr, 0);
        chk("ir_end_state", tap_state, 4'hC);

        // ---------------- tdo in SH_IR ----------------
        clear_counts();
        tms_v10 = 10'b0110000011;
        ir_v10  = 10'b0001101000;
        for (int i = 0; i < 10; i++) begin
            ir_so = ir_v10[i];
            dr_so = ~ir_v10[i];
            tck_cycle(tms_v10[i], 1'b0);
            if (i == 2) chk("tdo_en_cap_ir", tdo_en, 1'b0);
            if (i >= 3 && i <= 6) begin
                chk($sformatf("tdo_ir_bit%0d", i - 3), tdo, ir_v10[i]);
                chk($sformatf("tdo_en_ir_bit%0d", i - 3), tdo_en, 1'b1);
            end
            if (i == 7) begin
                chk("tdo_en_ex1_ir", tdo_en, 1'b0);
                chk("tdo_hold_ex1_ir", tdo, 1'b1);
            end
        end
        chk("tdo_ir_end_state", tap_state, 4'hC);

        // ---------------- DR scan with pause ----------------
        clear_counts();
        tms_v16 = 16'h6421;
        dr_v16  = 16'h1014;
        for (int i = 0; i < 16; i++) begin
            dr_so = dr_v16[i];
            ir_so = ~dr_v16[i];
            tck_cycle(tms_v16[i], 1'b0);
            if (i == 2 || i == 3 || i == 4 || i == 11 || i == 12) begin
                chk($sformatf("tdo_dr_p%0d", i), tdo, dr_v16[i]);
                chk($sformatf("tdo_en_dr_p%0d", i), tdo_en, 1'b1);
            end
            if (i == 5 || i == 13) chk($sformatf("tdo_en_ex1_dr_p%0d", i), tdo_en, 1'b0);
            if (i == 9) chk("dr_in_pause", tap_state, 4'h3);
        end
        chk("dr_clk_cnt", c_clk_dr, 6);
        chk("dr_shift_cnt", c_sh_dr, 5);
        chk("dr_pause_clk", c_pau_dr, 0);
        chk("dr_upd_cnt", c_upd_dr, 1);
        chk("dr_no_ir", c_clk_ir + c_upd_ir, 0);
        chk("dr_end_state", tap_state, 4'hC);
        ir_so = 1'b0;
        dr_so = 1'b0;

        // ---------------- five tms=1 reach TLR from every state ----------------
        for (int k = 0; k < 5; k++) tck_cycle(1'b1, 1'b0);
        chk("tlr_from_rti", tap_state, 4'hF);
        for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < path_len[s]; j++) tck_cycle(path_bits[s][j], 1'b0);
            chk($sformatf("path_to_%0h", path_st[s]), tap_state, path_st[s]);
            for (int k = 0; k < 5; k++) tck_cycle(1'b1, 1'b0);
            chk($sformatf("tlr_from_%0h", path_st[s]), tap_state, 4'hF);
        end

        // ---------------- reset in the middle of an IR shift ----------------
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tck_cycle(1'b0, 1'b1);
        chk("mid_in_shift_ir", tap_state, 4'hA);
        clear_counts();
        tms = 1'b0;
        tck = 1'b1;
        repeat (2) @(negedge iclk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_state", tap_state, 4'hF);
        chk("mid_rst_shift_ir", shift_ir, 1'b0);
        chk("mid_rst_tlr", tlr, 1'b1);
        for (int i = 0; i < 4; i++) begin
            repeat (HALF) @(negedge iclk);
            tck = ~tck;
        end
        repeat (HALF) @(negedge iclk);
        resetn = 1'b1;
        repeat (20) @(negedge iclk);
        chk("mid_no_spurious_rise", tap_state, 4'hF);
        tck = 1'b0;
        repeat (HALF) @(negedge iclk);
        tck_cycle(1'b0, 1'b0);
        chk("mid_after_rti", tap_state, 4'hC);
        chk("mid_no_update_ir", c_upd_ir, 0);
        chk("mid_no_update_dr", c_upd_dr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
